// File: rtl/cisc_control_unit_pkg.sv
// Shared types for the CISC control unit: FSM states, opcodes and the
// datapath control-word layout.
package cisc_control_unit_pkg;

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    ALU    = 4'd3,
    ADDR   = 4'd4,
    MRD    = 4'd5,
    MWR    = 4'd6,
    IMM    = 4'd7,
    JMP    = 4'd8,
    JC     = 4'd9,
    HALT   = 4'd10
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_LDI  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_JC   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  localparam logic [3:0] FUN_PASSA = 4'h0;

  localparam logic [1:0] PC_SEL_DATA = 2'd0;
  localparam logic [1:0] PC_SEL_ZERO = 2'd2;
  localparam logic [1:0] PC_SEL_INC  = 2'd3;

  // Field order is MSB first, so bit 31 is the top of reserved and bit 0 is load_ir.
  typedef struct packed {
    logic [1:0] reserved;
    logic [2:0] read_addr_b;
    logic [2:0] read_addr_a;
    logic [2:0] write_addr;
    logic [1:0] select_s;
    logic       load_s;
    logic [3:0] fun;
    logic       wire_select;
    logic       write_enable;
    logic       oe_dr;
    logic       select_dr;
    logic       load_dr;
    logic       oe_ar;
    logic       select_ar;
    logic       load_ar;
    logic       oe_pcd;
    logic       oe_pca;
    logic [1:0] select_pc;
    logic       load_pc;
    logic       load_ir;
  } cw_t;

endpackage

// File: rtl/cisc_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle. The control unit is the
// master; the datapath and memory sit on the slave side.
interface cisc_control_unit_if;
  logic [15:0] IR;
  logic        Cond;
  logic        MemReady;
  logic [31:0] ControlWord;
  logic        MemRead;
  logic        MemWrite;
  logic        Halted;
  logic        Fault;

  // MemRead/MemWrite act as valid and MemReady as ready: a request stays
  // high, unchanged, until the cycle MemReady is seen (or the wait times out).
  modport master (
    input  IR, Cond, MemReady,
    output ControlWord, MemRead, MemWrite, Halted, Fault
  );

  modport slave (
    output IR, Cond, MemReady,
    input  ControlWord, MemRead, MemWrite, Halted, Fault
  );
endinterface

// File: rtl/cisc_control_unit_mem_wait_timer.sv
// Counts unanswered cycles of an outstanding memory request and flags the
// cycle in which the wait budget is used up.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expired
);
  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign expired = active && !ready && (count == CNT_W'(WAIT_LIMIT - 1));

  // Every memory state is left on ready or expiry, so clearing here also
  // guarantees a zero count on entry to the next memory state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || ready || expired) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/cisc_control_unit.sv
// Microsequencer for a small CISC datapath: fetch/decode/execute FSM, the
// control-word decode for each state, and the memory-timeout fault.
module cisc_control_unit
  import cisc_control_unit_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cisc_control_unit_if.master  bus,
  output state_t               state_dbg
);

  state_t     state;
  logic       fault;
  cw_t        cw;
  logic       mem_read;
  logic       mem_write;
  logic       timeout;
  logic       jc_taken;
  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] sub;

  assign opcode   = bus.IR[15:12];
  assign rd       = bus.IR[11:9];
  assign ra       = bus.IR[8:6];
  assign rb       = bus.IR[5:3];
  assign sub      = bus.IR[2:0];
  assign jc_taken = bus.Cond ^ sub[2];

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (mem_read | mem_write),
    .ready   (bus.MemReady),
    .expired (timeout)
  );

  // Completion fields depend on MemReady/Cond in the same cycle, so the word
  // is decoded from the state register rather than pipelined behind it.
  always_comb begin
    cw        = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      RST: begin
        cw.load_pc   = 1'b1;
        cw.select_pc = PC_SEL_ZERO;
      end
      FETCH: begin
        cw.oe_pca = 1'b1;
        mem_read  = 1'b1;
        if (bus.MemReady) begin
          cw.load_ir   = 1'b1;
          cw.load_pc   = 1'b1;
          cw.select_pc = PC_SEL_INC;
        end
      end
      ALU: begin
        cw.read_addr_a  = ra;
        cw.read_addr_b  = rb;
        cw.fun          = {1'b1, sub};
        cw.write_addr   = rd;
        cw.write_enable = 1'b1;
        cw.load_s       = 1'b1;
      end
      ADDR: begin
        cw.read_addr_a = ra;
        cw.fun         = FUN_PASSA;
        cw.load_ar     = 1'b1;
        cw.select_ar   = 1'b1;
        if (opcode == OP_ST) begin
          cw.read_addr_b = rb;
          cw.load_dr     = 1'b1;
          cw.select_dr   = 1'b1;
        end
      end
      MRD: begin
        cw.oe_ar = 1'b1;
        mem_read = 1'b1;
        if (bus.MemReady) begin
          cw.wire_select  = 1'b1;
          cw.write_addr   = rd;
          cw.write_enable = 1'b1;
        end
      end
      MWR: begin
        cw.oe_ar  = 1'b1;
        cw.oe_dr  = 1'b1;
        mem_write = 1'b1;
      end
      IMM: begin
        cw.oe_pca = 1'b1;
        mem_read  = 1'b1;
        if (bus.MemReady) begin
          cw.wire_select  = 1'b1;
          cw.write_addr   = rd;
          cw.write_enable = 1'b1;
          cw.load_pc      = 1'b1;
          cw.select_pc    = PC_SEL_INC;
        end
      end
      JMP: begin
        cw.oe_pca = 1'b1;
        mem_read  = 1'b1;
        if (bus.MemReady) begin
          cw.load_pc   = 1'b1;
          cw.select_pc = PC_SEL_DATA;
        end
      end
      JC: begin
        cw.select_s = sub[1:0];
        if (jc_taken) begin
          cw.oe_pca = 1'b1;
          mem_read  = 1'b1;
          if (bus.MemReady) begin
            cw.load_pc   = 1'b1;
            cw.select_pc = PC_SEL_DATA;
          end
        end else begin
          cw.load_pc   = 1'b1;
          cw.select_pc = PC_SEL_INC;
        end
      end
      default: ;
    endcase
  end

  // Outputs are forced low while rst_n is low so an aborted access never
  // leaves a request or write enable on the bus.
  assign bus.ControlWord = rst_n ? cw : '0;
  assign bus.MemRead     = rst_n & mem_read;
  assign bus.MemWrite    = rst_n & mem_write;
  assign bus.Halted      = (state == HALT);
  assign bus.Fault       = fault;
  assign state_dbg       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
      fault <= 1'b0;
    end else begin
      case (state)
        RST: state <= FETCH;
        FETCH: begin
          if (timeout) begin
            state <= HALT;
            fault <= 1'b1;
          end else if (bus.MemReady) begin
            state <= DECODE;
          end
        end
        DECODE: begin
          case (opcode)
            OP_ALU:  state <= ALU;
            OP_LD:   state <= ADDR;
            OP_ST:   state <= ADDR;
            OP_LDI:  state <= IMM;
            OP_JMP:  state <= JMP;
            OP_JC:   state <= JC;
            OP_HALT: state <= HALT;
            default: state <= FETCH;
          endcase
        end
        ALU:  state <= FETCH;
        ADDR: state <= (opcode == OP_ST) ? MWR : MRD;
        MRD, MWR, IMM, JMP: begin
          if (timeout) begin
            state <= HALT;
            fault <= 1'b1;
          end else if (bus.MemReady) begin
            state <= FETCH;
          end
        end
        JC: begin
          // Cond is re-sampled while a taken jump waits on memory.
          if (!jc_taken) begin
            state <= FETCH;
          end else if (timeout) begin
            state <= HALT;
            fault <= 1'b1;
          end else if (bus.MemReady) begin
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= RST;
      endcase
    end
  end

endmodule

// File: tb/tb_cisc_control_unit.sv
// Directed bench for cisc_control_unit: a per-cycle vector table for the
// instruction flows plus hand sequences for timeout and mid-access reset.
module tb_cisc_control_unit;
  import cisc_control_unit_pkg::*;

  localparam logic [31:0] LOAD_IR = 32'h0000_0001;
  localparam logic [31:0] LOAD_PC = 32'h0000_0002;
  localparam logic [31:0] SEL_PC2 = 32'h0000_0008;
  localparam logic [31:0] SEL_PC3 = 32'h0000_000C;
  localparam logic [31:0] OE_PCA  = 32'h0000_0010;
  localparam logic [31:0] LOAD_AR = 32'h0000_0040;
  localparam logic [31:0] SEL_AR  = 32'h0000_0080;
  localparam logic [31:0] OE_AR   = 32'h0000_0100;
  localparam logic [31:0] LOAD_DR = 32'h0000_0200;
  localparam logic [31:0] SEL_DR  = 32'h0000_0400;
  localparam logic [31:0] OE_DR   = 32'h0000_0800;
  localparam logic [31:0] WE      = 32'h0000_1000;
  localparam logic [31:0] WIRE    = 32'h0000_2000;
  localparam logic [31:0] LOAD_S  = 32'h0004_0000;
  localparam logic [31:0] FW      = OE_PCA | LOAD_IR | LOAD_PC | SEL_PC3;
  localparam logic [31:0] RST_CW  = LOAD_PC | SEL_PC2;

  typedef struct {
    logic [15:0] ir;
    logic        cond;
    logic        ready;
    logic [31:0] cw;
    logic        mr;
    logic        mw;
    logic        halted;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     n_checks = 0;
  int     n_fail   = 0;
  vec_t   vecs[$];

  cisc_control_unit_if bus();

  cisc_control_unit #(.WAIT_LIMIT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] fun_f(input int v);
    logic [31:0] x = 32'(v);
    return x << 14;
  endfunction
  function automatic logic [31:0] sels_f(input int v);
    logic [31:0] x = 32'(v);
    return x << 19;
  endfunction
  function automatic logic [31:0] wa_f(input int v);
    logic [31:0] x = 32'(v);
    return x << 21;
  endfunction
  function automatic logic [31:0] ra_f(input int v);
    logic [31:0] x = 32'(v);
    return x << 24;
  endfunction
  function automatic logic [31:0] rb_f(input int v);
    logic [31:0] x = 32'(v);
    return x << 27;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ir, input logic cond, input logic ready,
                     input logic [31:0] cw, input logic mr, input logic mw,
                     input logic halted);
    vec_t v;
    v.ir = ir; v.cond = cond; v.ready = ready;
    v.cw = cw; v.mr = mr; v.mw = mw; v.halted = halted;
    vecs.push_back(v);
  endtask

  // driver: one cycle per vector, inputs after the edge, outputs at negedge
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    bus.IR       = v.ir;
    bus.Cond     = v.cond;
    bus.MemReady = v.ready;
    @(negedge clk);
    check({tag, "_cw"},     bus.ControlWord,     v.cw);
    check({tag, "_mr"},     32'(bus.MemRead),    32'(v.mr));
    check({tag, "_mw"},     32'(bus.MemWrite),   32'(v.mw));
    check({tag, "_halted"}, 32'(bus.Halted),     32'(v.halted));
    check({tag, "_fault"},  32'(bus.Fault),      32'h0);
  endtask

  task automatic reset_and_release(input string tag);
    rst_n        = 1'b0;
    bus.IR       = 16'h0000;
    bus.Cond     = 1'b0;
    bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_inrst_cw"},     bus.ControlWord,   32'h0);
    check({tag, "_inrst_mr"},     32'(bus.MemRead),  32'h0);
    check({tag, "_inrst_halted"}, 32'(bus.Halted),   32'h0);
    check({tag, "_inrst_fault"},  32'(bus.Fault),    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_rst_cw"}, bus.ControlWord, RST_CW);
    check({tag, "_rst_mr"}, 32'(bus.MemRead), 32'h0);
  endtask

  initial begin
    int high_cycles;
    vec_t v;

    // NOP stream: FETCH/DECODE alternate
    add(16'h0000, 0, 1, FW, 1, 0, 0);
    add(16'h0000, 0, 1, '0, 0, 0, 0);
    add(16'h0000, 0, 1, FW, 1, 0, 0);
    add(16'h0000, 0, 1, '0, 0, 0, 0);
    // ALU rd=1 ra=1 rb=2 sub=0, one FETCH wait
    add(16'h1250, 0, 0, OE_PCA, 1, 0, 0);
    add(16'h1250, 0, 1, FW, 1, 0, 0);
    add(16'h1250, 0, 1, '0, 0, 0, 0);
    add(16'h1250, 0, 1, rb_f(2) | ra_f(1) | wa_f(1) | fun_f(8) | WE | LOAD_S, 0, 0, 0);
    // LD rd=1 ra=1 with three MRD wait cycles
    add(16'h2240, 0, 1, FW, 1, 0, 0);
    add(16'h2240, 0, 1, '0, 0, 0, 0);
    add(16'h2240, 0, 1, ra_f(1) | fun_f(0) | LOAD_AR | SEL_AR, 0, 0, 0);
    add(16'h2240, 0, 0, OE_AR, 1, 0, 0);
    add(16'h2240, 0, 0, OE_AR, 1, 0, 0);
    add(16'h2240, 0, 0, OE_AR, 1, 0, 0);
    add(16'h2240, 0, 1, OE_AR | WIRE | wa_f(1) | WE, 1, 0, 0);
    // ST ra=2 rb=3 with one MWR wait
    add(16'h3298, 0, 1, FW, 1, 0, 0);
    add(16'h3298, 0, 1, '0, 0, 0, 0);
    add(16'h3298, 0, 1, ra_f(2) | rb_f(3) | LOAD_AR | SEL_AR | LOAD_DR | SEL_DR, 0, 0, 0);
    add(16'h3298, 0, 0, OE_AR | OE_DR, 0, 1, 0);
    add(16'h3298, 0, 1, OE_AR | OE_DR, 0, 1, 0);
    // LDI rd=5
    add(16'h4A00, 0, 1, FW, 1, 0, 0);
    add(16'h4A00, 0, 1, '0, 0, 0, 0);
    add(16'h4A00, 0, 1, OE_PCA | WIRE | wa_f(5) | WE | LOAD_PC | SEL_PC3, 1, 0, 0);
    // JMP
    add(16'h5000, 0, 1, FW, 1, 0, 0);
    add(16'h5000, 0, 1, '0, 0, 0, 0);
    add(16'h5000, 0, 1, OE_PCA | LOAD_PC, 1, 0, 0);
    // JC sub=4 Cond=0: taken, one wait
    add(16'h6004, 0, 1, FW, 1, 0, 0);
    add(16'h6004, 0, 1, '0, 0, 0, 0);
    add(16'h6004, 0, 0, sels_f(0) | OE_PCA, 1, 0, 0);
    add(16'h6004, 0, 1, sels_f(0) | OE_PCA | LOAD_PC, 1, 0, 0);
    // JC sub=0 Cond=0: not taken, MemReady ignored
    add(16'h6000, 0, 1, FW, 1, 0, 0);
    add(16'h6000, 0, 1, '0, 0, 0, 0);
    add(16'h6000, 0, 1, LOAD_PC | SEL_PC3, 0, 0, 0);
    // JC sub=3 Cond=1: taken
    add(16'h6003, 1, 1, FW, 1, 0, 0);
    add(16'h6003, 1, 1, '0, 0, 0, 0);
    add(16'h6003, 1, 1, sels_f(3) | OE_PCA | LOAD_PC, 1, 0, 0);
    // JC sub=5 Cond=1: not taken
    add(16'h6005, 1, 1, FW, 1, 0, 0);
    add(16'h6005, 1, 1, '0, 0, 0, 0);
    add(16'h6005, 1, 0, sels_f(1) | LOAD_PC | SEL_PC3, 0, 0, 0);
    // opcode 9 behaves as NOP
    add(16'h9000, 0, 1, FW, 1, 0, 0);
    add(16'h9000, 0, 1, '0, 0, 0, 0);
    // HALT, MemReady ignored afterwards
    add(16'h7000, 0, 1, FW, 1, 0, 0);
    add(16'h7000, 0, 1, '0, 0, 0, 0);
    add(16'h7000, 0, 1, '0, 0, 0, 1);
    add(16'h7000, 0, 0, '0, 0, 0, 1);
    add(16'h7000, 0, 1, '0, 0, 0, 1);

    reset_and_release("tbl");
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // FETCH timeout: MemRead must stay high exactly 15 cycles
    reset_and_release("to");
    high_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      bus.MemReady = 1'b0;
      @(negedge clk);
      if (bus.MemRead !== 1'b1) break;
      high_cycles++;
    end
    check("to_mr_cycles", 32'(high_cycles), 32'd15);
    check("to_fault",  32'(bus.Fault),  32'h1);
    check("to_halted", 32'(bus.Halted), 32'h1);
    check("to_cw",     bus.ControlWord, 32'h0);
    repeat (4) begin
      @(posedge clk);
      #1;
      bus.MemReady = 1'b1;
      @(negedge clk);
      check("to_hold_fault",  32'(bus.Fault),   32'h1);
      check("to_hold_halted", 32'(bus.Halted),  32'h1);
      check("to_hold_mr",     32'(bus.MemRead), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    check("to_rst_fault",  32'(bus.Fault),  32'h0);
    check("to_rst_halted", 32'(bus.Halted), 32'h0);

    // reset asserted while a store is waiting in MWR
    reset_and_release("mwr");
    v = '{ir: 16'h3298, cond: 1'b0, ready: 1'b1, cw: FW, mr: 1'b1, mw: 1'b0, halted: 1'b0};
    apply(v, "mwr_fetch");
    v.cw = '0; v.mr = 1'b0;
    apply(v, "mwr_decode");
    v.cw = ra_f(2) | rb_f(3) | LOAD_AR | SEL_AR | LOAD_DR | SEL_DR;
    apply(v, "mwr_addr");
    v.ready = 1'b0; v.cw = OE_AR | OE_DR; v.mw = 1'b1;
    apply(v, "mwr_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("mwr_abort_mw",    32'(bus.MemWrite),  32'h0);
    check("mwr_abort_cw",    bus.ControlWord,    32'h0);
    check("mwr_abort_fault", 32'(bus.Fault),     32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.MemReady = 1'b1;
    @(negedge clk);
    check("mwr_restart_cw", bus.ControlWord, RST_CW);
    @(posedge clk);
    @(negedge clk);
    check("mwr_restart_fetch", bus.ControlWord, FW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
